// File: rtl/synth_pipe_pkg.sv
// Shared definitions for the synth voice pipeline: voice state encoding and
// note-word field layout.
package synth_pipe_pkg;

  localparam int NOTE_W   = 16;
  localparam int RSV_BIT  = 15;
  localparam int MIDI_LSB = 8;
  localparam int MIDI_W   = 7;
  localparam int VEL_LSB  = 0;
  localparam int VEL_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BSY  = 2'b01,
    RDY  = 2'b10
  } voice_state_t;

  // Any field change (including velocity) counts as a new note.
  function automatic logic note_differs(input logic [NOTE_W-1:0] a,
                                        input logic [NOTE_W-1:0] b);
    return (a[MIDI_LSB +: MIDI_W] != b[MIDI_LSB +: MIDI_W]) ||
           (a[VEL_LSB +: VEL_W]   != b[VEL_LSB +: VEL_W])   ||
           (a[RSV_BIT]            != b[RSV_BIT]);
  endfunction

endpackage

// File: rtl/voice_fsm.sv
// One voice's IDLE/BSY/RDY warm-up FSM with its tick counter and latched note word.
// state_nxt is exported so the parent can register aggregate counts on the same edge.
module voice_fsm
  import synth_pipe_pkg::*;
#(
  parameter int SRC_LAT  = 3,
  parameter int FILT_LAT = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [NOTE_W-1:0] d,
  output logic [1:0]        state,
  output logic [1:0]        state_nxt,
  output logic              filt_ena
);

  localparam logic [CNT_W-1:0] SRC_PT = CNT_W'(SRC_LAT);
  localparam logic [CNT_W-1:0] RDY_PT = CNT_W'(SRC_LAT + FILT_LAT);

  voice_state_t      st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NOTE_W-1:0] latch_q, latch_d;
  logic              fe_q, fe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      latch_q <= '0;
      fe_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    fe_d    = fe_q;
    if (clk_en) begin
      if (d == '0) begin
        st_d    = IDLE;
        cnt_d   = '0;
        latch_d = '0;
        fe_d    = 1'b0;
      end else if (st_q == IDLE || note_differs(d, latch_q)) begin
        st_d    = BSY;
        cnt_d   = CNT_W'(1);
        latch_d = d;
        fe_d    = 1'b0;
      end else if (st_q == BSY) begin
        if (cnt_q >= SRC_PT) fe_d = 1'b1;
        if (cnt_q >= RDY_PT) st_d = RDY;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign state     = st_q;
  assign state_nxt = st_d;
  assign filt_ena  = fe_q;

endmodule

// File: rtl/voice_pipeline_ctrl.sv
// Multi-voice pipeline controller: per-voice warm-up FSMs plus a sequential
// mixer that sums RDY voices one per clk after each sample tick.
module voice_pipeline_ctrl
  import synth_pipe_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int SRC_LAT    = 3,
  parameter int FILT_LAT   = 4,
  parameter int CNT_W      = 4,
  parameter int MIX_W      = SAMPLE_W + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1),
  localparam int ACT_W     = $clog2(NUM_VOICES + 1),
  localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic [NOTE_W*NUM_VOICES-1:0]   i_data,
  input  logic [SAMPLE_W*NUM_VOICES-1:0] i_sample,
  output logic [NUM_VOICES-1:0]          o_filt_ena,
  output logic [2*NUM_VOICES-1:0]        o_state,
  output logic [ACT_W-1:0]               o_active_cnt,
  output logic [MIX_W-1:0]               o_mix,
  output logic                           o_mix_valid
);

  logic [2*NUM_VOICES-1:0] state_nxt;

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
    voice_fsm #(
      .SRC_LAT (SRC_LAT),
      .FILT_LAT(FILT_LAT),
      .CNT_W   (CNT_W)
    ) u_voice (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .d        (i_data[k*NOTE_W +: NOTE_W]),
      .state    (o_state[2*k +: 2]),
      .state_nxt(state_nxt[2*k +: 2]),
      .filt_ena (o_filt_ena[k])
    );
  end

  logic [ACT_W-1:0] act_d;

  always_comb begin
    act_d = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (state_nxt[2*k +: 2] != IDLE) act_d = act_d + ACT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         o_active_cnt <= '0;
    else if (clk_en) o_active_cnt <= act_d;
  end

  // Scan reads the registered states, i.e. the states as of the last tick edge.
  logic             scan_busy;
  logic [IDX_W-1:0] idx;
  logic [MIX_W-1:0] acc, addend, acc_sum;
  logic             last;

  always_comb begin
    addend = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (IDX_W'(k) == idx && o_state[2*k +: 2] == RDY) begin
        addend = {{(MIX_W-SAMPLE_W){i_sample[k*SAMPLE_W + SAMPLE_W-1]}},
                  i_sample[k*SAMPLE_W +: SAMPLE_W]};
      end
    end
  end

  assign acc_sum = acc + addend;
  assign last    = (idx == IDX_W'(NUM_VOICES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_busy   <= 1'b0;
      idx         <= '0;
      acc         <= '0;
      o_mix       <= '0;
      o_mix_valid <= 1'b0;
    end else begin
      o_mix_valid <= 1'b0;
      if (clk_en) begin
        scan_busy <= 1'b1;
        idx       <= '0;
        acc       <= '0;
      end else if (scan_busy) begin
        acc <= acc_sum;
        idx <= idx + IDX_W'(1);
        if (last) begin
          o_mix       <= acc_sum;
          o_mix_valid <= 1'b1;
          scan_busy   <= 1'b0;
          idx         <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_pipeline_ctrl.sv
// Bench for voice_pipeline_ctrl: age-based voice model, per-cycle compare,
// directed scenarios with hand-computed literal expectations.
module tb_voice_pipeline_ctrl;

  localparam int NV   = 4;
  localparam int SW   = 16;
  localparam int MW   = 18;
  localparam int AW   = 3;
  localparam int SRC  = 3;
  localparam int FILT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clk_en = 1'b0;
  logic [16*NV-1:0] i_data = '0;
  logic [SW*NV-1:0] i_sample = '0;
  logic [NV-1:0]   o_filt_ena;
  logic [2*NV-1:0] o_state;
  logic [AW-1:0]   o_active_cnt;
  logic [MW-1:0]   o_mix;
  logic            o_mix_valid;

  voice_pipeline_ctrl #(
    .NUM_VOICES(NV), .SAMPLE_W(SW), .SRC_LAT(SRC), .FILT_LAT(FILT), .CNT_W(4), .MIX_W(MW)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_data(i_data), .i_sample(i_sample),
    .o_filt_ena(o_filt_ena), .o_state(o_state), .o_active_cnt(o_active_cnt),
    .o_mix(o_mix), .o_mix_valid(o_mix_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each voice is described by ticks elapsed since its last (re)trigger; 0 = off.
  int          age[NV];
  logic [15:0] mlatch[NV];
  int          pend;
  logic [MW-1:0] pend_sum;
  logic [MW-1:0] exp_mix;
  logic        exp_valid;
  logic [MW-1:0] exp_q[$];

  function automatic logic [1:0] age_state(input int a);
    if (a == 0) return 2'b00;
    if (a >= SRC + FILT + 1) return 2'b10;
    return 2'b01;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NV; k++) begin
        age[k] = 0;
        mlatch[k] = '0;
      end
      pend = 0;
      pend_sum = '0;
      exp_mix = '0;
      exp_valid = 1'b0;
      exp_q.delete();
    end else begin
      exp_valid = 1'b0;
      if (clk_en) begin
        int sum;
        for (int k = 0; k < NV; k++) begin
          logic [15:0] d;
          d = i_data[16*k +: 16];
          if (d == 16'h0) begin
            age[k] = 0;
            mlatch[k] = '0;
          end else if (d != mlatch[k]) begin
            mlatch[k] = d;
            age[k] = 1;
          end else if (age[k] < 1000) begin
            age[k]++;
          end
        end
        sum = 0;
        for (int k = 0; k < NV; k++)
          if (age_state(age[k]) == 2'b10) sum += int'($signed(i_sample[k*SW +: SW]));
        pend_sum = MW'(sum);
        pend = NV;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          exp_mix = pend_sum;
          exp_valid = 1'b1;
          exp_q.push_back(pend_sum);
        end
      end
    end
  end

  function automatic logic [2*NV-1:0] exp_state_vec();
    logic [2*NV-1:0] v;
    for (int k = 0; k < NV; k++) v[2*k +: 2] = age_state(age[k]);
    return v;
  endfunction

  function automatic logic [NV-1:0] exp_fe_vec();
    logic [NV-1:0] v;
    for (int k = 0; k < NV; k++) v[k] = (age[k] >= SRC + 1);
    return v;
  endfunction

  function automatic logic [AW-1:0] exp_act();
    int n;
    n = 0;
    for (int k = 0; k < NV; k++) if (age[k] != 0) n++;
    return AW'(n);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("state", o_state, exp_state_vec());
      check("filt_ena", o_filt_ena, exp_fe_vec());
      check("active_cnt", o_active_cnt, exp_act());
      check("mix_valid", o_mix_valid, exp_valid);
      check("mix_hold", o_mix, exp_mix);
      if (o_mix_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL mix_result: got pulse with %0h, expected no pulse at %0t", o_mix, $time);
        end else begin
          check("mix_result", o_mix, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int gap, output int lat);
    @(posedge clk); #2 clk_en = 1'b1;
    @(posedge clk); #2 clk_en = 1'b0;
    lat = -1;
    for (int n = 1; n <= gap; n++) begin
      @(posedge clk); #1;
      if (o_mix_valid && lat < 0) lat = n;
    end
  endtask

  task automatic ticks(input int n);
    int lat;
    for (int i = 0; i < n; i++) tick(6, lat);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int pulses;

    #1 rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_state", o_state, 8'h00);
    check("rst_fe", o_filt_ena, 4'h0);
    check("rst_act", o_active_cnt, 3'd0);
    check("rst_mix", o_mix, 18'h0);
    check("rst_valid", o_mix_valid, 1'b0);

    // Note-on warm-up on voice 0
    i_data[15:0] = 16'h3C40;
    tick(6, lat);
    check("t1_state", o_state[1:0], 2'b01);
    check("t1_fe", o_filt_ena[0], 1'b0);
    ticks(2);
    check("t3_fe", o_filt_ena[0], 1'b0);
    ticks(1);
    check("t4_fe", o_filt_ena[0], 1'b1);
    check("t4_state", o_state[1:0], 2'b01);
    ticks(3);
    check("t7_state", o_state[1:0], 2'b01);
    ticks(1);
    check("t8_state", o_state[1:0], 2'b10);
    check("t8_act", o_active_cnt, 3'd1);

    // Velocity-only change retriggers
    i_data[15:0] = 16'h4040;
    tick(6, lat);
    check("rt_state", o_state[1:0], 2'b01);
    check("rt_fe", o_filt_ena[0], 1'b0);
    ticks(6);
    check("rt6_state", o_state[1:0], 2'b01);
    ticks(1);
    check("rt7_state", o_state[1:0], 2'b10);

    // Mix of three RDY voices, voice 3 still busy
    i_sample = {16'h1234, 16'hFFFF, 16'h7FFF, 16'h7FFF};
    i_data[31:16] = 16'h4050;
    i_data[47:32] = 16'h4860;
    ticks(7);
    i_data[63:48] = 16'h3000;
    tick(6, lat);
    check("mix3_state", o_state, 8'b01_10_10_10);
    check("mix3_act", o_active_cnt, 3'd4);
    check("mix3_lat", lat, 4);
    check("mix3_val", o_mix, 18'h0FFFD);

    // Four RDY voices at full negative scale
    i_sample = {4{16'h8000}};
    ticks(7);
    check("mix4_state", o_state, 8'b10_10_10_10);
    check("mix4_val", o_mix, 18'h20000);

    // Back-to-back ticks 2 clks apart: first scan aborted
    pulses = 0;
    @(posedge clk); #2 clk_en = 1'b1;
    @(posedge clk); #2 clk_en = 1'b0;
    @(posedge clk); #1;
    if (o_mix_valid) pulses++;
    #1 i_sample = {4{16'h0001}};
    clk_en = 1'b1;
    @(posedge clk); #1;
    if (o_mix_valid) pulses++;
    #1 clk_en = 1'b0;
    for (int n = 0; n < 7; n++) begin
      @(posedge clk); #1;
      if (o_mix_valid) pulses++;
    end
    check("abort_pulses", pulses, 1);
    check("abort_mix", o_mix, 18'h00004);

    // Reset mid-scan with three RDY voices
    i_data[63:48] = 16'h0;
    tick(6, lat);
    check("pre_rst_act", o_active_cnt, 3'd3);
    @(posedge clk); #2 clk_en = 1'b1;
    @(posedge clk); #2 clk_en = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("mrst_state", o_state, 8'h00);
    check("mrst_fe", o_filt_ena, 4'h0);
    check("mrst_act", o_active_cnt, 3'd0);
    check("mrst_mix", o_mix, 18'h0);
    i_data = '0;
    i_data[15:0] = 16'h2A10;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (o_mix_valid) pulses++;
    end
    check("mrst_pulses", pulses, 0);
    #1 rst = 1'b0;
    tick(6, lat);
    check("post_rst_state", o_state, 8'h01);
    check("post_rst_act", o_active_cnt, 3'd1);
    check("post_rst_mix", o_mix, 18'h0);

    repeat (2) @(posedge clk);
    #1 check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/voice_pipeline_ctrl.md
# voice_pipeline_ctrl

Multi-voice successor to the single-voice pipeline controller. It runs one IDLE/BSY/RDY warm-up state machine per voice, drives each voice's filter enable, and retriggers a voice when its note changes. Between sample ticks it mixes the samples of all RDY voices with a sequential accumulator. It sits between the voice-assignment logic (per-voice note words in) and the output stage (mixed sample out), with the per-voice phase/LUT/filter datapaths hanging off it.

## Interface
- NUM_VOICES, 4: number of voices (≥1).
- SAMPLE_W, 16: per-voice signed sample width.
- SRC_LAT, 3: ticks from note-on until the source output is valid (filter enable point).
- FILT_LAT, 4: additional ticks until filter output is valid (RDY point).
- CNT_W, 4: warm-up counter width; must hold SRC_LAT+FILT_LAT.
- MIX_W, SAMPLE_W+$clog2(NUM_VOICES) (min SAMPLE_W+1): mix width.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  sample tick, one clk wide.
- i_data  in  16*NUM_VOICES  voice k at [16k+15:16k]; bit15 reserved, [14:8] MIDI note, [7:0] velocity; all-zero = voice off.
- i_sample  in  SAMPLE_W*NUM_VOICES  signed filtered sample of voice k, stable between ticks.
- o_filt_ena  out  NUM_VOICES  per-voice filter enable.
- o_state  out  2*NUM_VOICES  per-voice state: IDLE=00, BSY=01, RDY=10 (11 never driven).
- o_active_cnt  out  $clog2(NUM_VOICES+1)  count of non-IDLE voices.
- o_mix  out  MIX_W  signed sum of RDY voices' samples.
- o_mix_valid  out  1  one-clk pulse when o_mix updates.

## Operation
- Reset: all states IDLE, counters 0, latched note words 0, o_filt_ena 0, o_active_cnt 0, o_mix 0, o_mix_valid 0, scan idle.
- Voice FSMs update only on clk edges where clk_en=1. For voice k, with d = its i_data slice:
  - d==0, any state: IDLE; cnt 0; filt_ena 0; latch 0.
  - IDLE, d!=0: BSY; cnt 1; latch d.
  - BSY/RDY, d!=0, d!=latch: retrigger to BSY; cnt 1; filt_ena 0; latch d.
  - BSY, d==latch: if cnt≥SRC_LAT then filt_ena 1; if cnt≥SRC_LAT+FILT_LAT then RDY; cnt increments, saturating at all-ones.
  - RDY, d==latch: hold; cnt holds.
- A velocity-only change counts as a note change and retriggers.
- o_active_cnt is registered and updated on the same edge as the states.
- Mixer: a tick edge clears the accumulator and starts a scan at index 0. On each following clk, acc += sign-extend(i_sample[k]) if voice k's post-tick state is RDY, else +0; k increments. On the edge that adds voice NUM_VOICES-1: o_mix <= final sum, o_mix_valid=1 for that single cycle, scan goes idle.
- Sum cannot overflow MIX_W. No saturation.

## Timing
- Note-on applied before tick 1: BSY after tick 1; filt_ena after tick SRC_LAT+1 (4); RDY after tick SRC_LAT+FILT_LAT+1 (8).
- Mix latency: o_mix_valid is high during the cycle following edge T+NUM_VOICES, where T is the tick edge.
- Required clk_en spacing: ≥NUM_VOICES+1 clks. A tick during a scan aborts it: no valid pulse, o_mix unchanged, new scan starts from index 0.
- Ticks arriving during a scan still update the voice FSMs.
- rst mid-scan or mid-warm-up: immediate return to reset values. No valid pulse is generated for the aborted scan.
- Voice going IDLE/retriggered between tick and scan end: the scan uses the states registered at the tick edge.

## Structure
- Shared package synth_pipe_pkg: state encodings IDLE/BSY/RDY, note-word field offsets (MIDI [14:8], velocity [7:0]), NOTE_W=16.
- Sub-module voice_fsm: one voice's FSM, counter and latch. Instantiated NUM_VOICES times by generate.
- Scan/accumulator and active counter live in the top.

## Test plan
- Reset, then note 0x3C40 on voice 0 -> o_state[1:0] 01 after tick 1; o_filt_ena[0]=1 after tick 4; 10 after tick 8; o_active_cnt=1.
- Voice 0 RDY, i_data changes 0x3C40->0x4040 -> after next tick: state 01, filt_ena 0, reaches RDY again 7 ticks later.
- Voices 0,1,2 RDY with samples 0x7FFF, 0x7FFF, 0xFFFF; voice 3 BSY with 0x1234 -> o_mix=18'h0FFFD, o_mix_valid pulses 4 clks after the tick edge.
- All four voices RDY with 0x8000 -> o_mix=18'h20000 (−131072); no overflow.
- Ticks 2 clks apart with NUM_VOICES=4 -> first scan aborted, no valid pulse; only the second scan's result appears.
- rst asserted mid-scan with 3 voices RDY -> all outputs 0, no valid pulse; after release, a note-on restarts from IDLE.
